// File: rtl/color_pkg.sv
// Shared types and code constants for the colour-sensor scan sequencer.
// Channel order and sensor filter-pin encodings live here so the bench and RTL agree.
package color_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_MEASURE,
      ST_CLASSIFY
   } state_t;

   typedef enum logic [1:0] {
      CH_RED,
      CH_GREEN,
      CH_BLUE,
      CH_CLEAR
   } channel_t;

   localparam logic [1:0] FILT_RED   = 2'b00;
   localparam logic [1:0] FILT_BLUE  = 2'b01;
   localparam logic [1:0] FILT_CLEAR = 2'b10;
   localparam logic [1:0] FILT_GREEN = 2'b11;

   localparam logic [1:0] COLOR_NONE  = 2'd0;
   localparam logic [1:0] COLOR_RED   = 2'd1;
   localparam logic [1:0] COLOR_GREEN = 2'd2;
   localparam logic [1:0] COLOR_BLUE  = 2'd3;

   function automatic logic [1:0] filter_code(input channel_t ch);
      case (ch)
         CH_RED:   return FILT_RED;
         CH_GREEN: return FILT_GREEN;
         CH_BLUE:  return FILT_BLUE;
         default:  return FILT_CLEAR;
      endcase
   endfunction

   function automatic channel_t next_channel(input channel_t ch);
      case (ch)
         CH_RED:   return CH_GREEN;
         CH_GREEN: return CH_BLUE;
         default:  return CH_CLEAR;
      endcase
   endfunction

endpackage

// File: rtl/edge_counter.sv
// Synchronises the asynchronous sensor square wave and counts its rising edges.
// window_count already includes an edge seen this cycle, so the final window cycle is never lost.
module edge_counter #(
   parameter int CNT_W = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sensor_freq,
   input  logic             enable,
   input  logic             clear,
   output logic [CNT_W-1:0] window_count
);

   logic             sync_q1;
   logic             sync_q2;
   logic             edge_pulse;
   logic [CNT_W-1:0] count;

   assign edge_pulse   = sync_q1 & ~sync_q2;
   assign window_count = (enable && edge_pulse && (count != '1)) ? count + 1'b1 : count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         count   <= '0;
      end else begin
         sync_q1 <= sensor_freq;
         sync_q2 <= sync_q1;
         if (clear) count <= '0;
         else       count <= window_count;
      end
   end

endmodule

// File: rtl/color_scan_sequencer.sv
// Steps a colour sensor through red, green, blue and clear filters, counts each channel
// over a fixed window, then classifies the dominant colour against the clear channel.
module color_scan_sequencer
   import color_pkg::*;
#(
   parameter int WINDOW_CYCLES = 100000,
   parameter int SETTLE_CYCLES = 1000,
   parameter int CNT_W         = 17,
   parameter int THRESH_PCT    = 40
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             continuous,
   input  logic [1:0]       scale_sel,
   input  logic             sensor_freq,
   output logic [1:0]       s01,
   output logic [1:0]       s23,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] red_cnt,
   output logic [CNT_W-1:0] green_cnt,
   output logic [CNT_W-1:0] blue_cnt,
   output logic [CNT_W-1:0] clear_cnt,
   output logic [1:0]       color
);

   localparam int MAX_CYC = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
   localparam int TMR_W   = $clog2(MAX_CYC + 1);
   localparam int PROD_W  = CNT_W + 7;

   state_t             state, state_next;
   channel_t           channel;
   logic [TMR_W-1:0]   timer;
   logic [CNT_W-1:0]   shadow [4];
   logic [CNT_W-1:0]   window_count;
   logic               accept, settle_end, window_end;
   logic [1:0]         dom_code, color_next;
   logic [CNT_W-1:0]   dom_val;
   logic [PROD_W-1:0]  dom_prod, clr_prod;

   edge_counter #(.CNT_W(CNT_W)) u_edge_counter (
      .clk          (clk),
      .rst          (rst),
      .sensor_freq  (sensor_freq),
      .enable       (state == ST_MEASURE),
      .clear        (window_end),
      .window_count (window_count)
   );

   assign busy = (state != ST_IDLE);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_next = state;
      accept     = (state == ST_IDLE) && (start || (done && continuous));
      settle_end = (state == ST_SETTLE) && (timer == '0);
      window_end = (state == ST_MEASURE) && (timer == '0);
      case (state)
         ST_IDLE:     if (accept) state_next = ST_SETTLE;
         ST_SETTLE:   if (settle_end) state_next = ST_MEASURE;
         ST_MEASURE:  if (window_end) state_next = (channel == CH_CLEAR) ? ST_CLASSIFY : ST_SETTLE;
         ST_CLASSIFY: state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   // Ties favour red, then green, then blue.
   always_comb begin
      dom_code = COLOR_RED;
      dom_val  = shadow[CH_RED];
      if (!((shadow[CH_RED] >= shadow[CH_GREEN]) && (shadow[CH_RED] >= shadow[CH_BLUE]))) begin
         if (shadow[CH_GREEN] >= shadow[CH_BLUE]) begin
            dom_code = COLOR_GREEN;
            dom_val  = shadow[CH_GREEN];
         end else begin
            dom_code = COLOR_BLUE;
            dom_val  = shadow[CH_BLUE];
         end
      end
      dom_prod   = PROD_W'(dom_val) * PROD_W'(100);
      clr_prod   = PROD_W'(shadow[CH_CLEAR]) * PROD_W'(THRESH_PCT);
      color_next = ((shadow[CH_CLEAR] != '0) && (dom_prod >= clr_prod)) ? dom_code : COLOR_NONE;
   end

   // NOTE: the four-entry shadow array is small and must read zero after reset, so it is reset explicitly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         channel   <= CH_RED;
         timer     <= '0;
         s01       <= 2'b11;
         s23       <= FILT_RED;
         done      <= 1'b0;
         red_cnt   <= '0;
         green_cnt <= '0;
         blue_cnt  <= '0;
         clear_cnt <= '0;
         color     <= COLOR_NONE;
         for (int i = 0; i < 4; i++) shadow[i] <= '0;
      end else begin
         state <= state_next;
         done  <= (state == ST_CLASSIFY);
         if (accept) begin
            s01     <= scale_sel;
            channel <= CH_RED;
            s23     <= FILT_RED;
            timer   <= TMR_W'(SETTLE_CYCLES - 1);
         end else if (settle_end) begin
            timer <= TMR_W'(WINDOW_CYCLES - 1);
         end else if (window_end) begin
            shadow[channel] <= window_count;
            if (channel != CH_CLEAR) begin
               channel <= next_channel(channel);
               s23     <= filter_code(next_channel(channel));
               timer   <= TMR_W'(SETTLE_CYCLES - 1);
            end
         end else if (timer != '0) begin
            timer <= timer - 1'b1;
         end
         if (state == ST_CLASSIFY) begin
            red_cnt   <= shadow[CH_RED];
            green_cnt <= shadow[CH_GREEN];
            blue_cnt  <= shadow[CH_BLUE];
            clear_cnt <= shadow[CH_CLEAR];
            color     <= color_next;
         end
      end
   end

endmodule

// File: tb/tb_color_scan_sequencer.sv
// Directed bench for color_scan_sequencer: full scans with known edge counts per channel,
// mid-scan reset, start-while-busy and continuous re-triggering.
module tb_color_scan_sequencer;

   localparam int W  = 100;
   localparam int S  = 10;
   localparam int CW = 8;
   localparam int TP = 40;

   logic          clk = 1'b0;
   logic          rst, start, continuous, sensor_freq;
   logic [1:0]    scale_sel;
   logic [1:0]    s01, s23, color;
   logic          busy, done;
   logic [CW-1:0] red_cnt, green_cnt, blue_cnt, clear_cnt;

   int checks = 0;
   int errors = 0;

   color_scan_sequencer #(
      .WINDOW_CYCLES (W),
      .SETTLE_CYCLES (S),
      .CNT_W         (CW),
      .THRESH_PCT    (TP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .continuous  (continuous),
      .scale_sel   (scale_sel),
      .sensor_freq (sensor_freq),
      .s01         (s01),
      .s23         (s23),
      .busy        (busy),
      .done        (done),
      .red_cnt     (red_cnt),
      .green_cnt   (green_cnt),
      .blue_cnt    (blue_cnt),
      .clear_cnt   (clear_cnt),
      .color       (color)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Per-channel pattern, i = cycle within the 110-cycle settle+window slot.
   // n<0: period-4 wave (25 edges/window); n>=50: toggle each cycle (50 edges);
   // otherwise a burst of n single-cycle pulses well inside the window.
   function automatic logic sensor_val(input int n, input int i);
      if (n < 0)   return i[1];
      if (n >= 50) return i[0];
      return (i >= 20) && (i < 20 + 2 * n) && !i[0];
   endfunction

   task automatic start_scan(input logic [1:0] sel);
      scale_sel = sel;
      start     = 1'b1;
      step();
      start = 1'b0;
      check("busy_after_start", busy, 1'b1);
      check("s01_latched", s01, sel);
      check("s23_red", s23, 2'b00);
   endtask

   // Called in the first SETTLE cycle; returns in the CLASSIFY cycle.
   task automatic drive_scan(input int nr, input int ng, input int nb, input int nc,
                             input int repulse_ch);
      int         n [4];
      logic [1:0] code [4];
      int         done_seen;
      n         = '{nr, ng, nb, nc};
      code      = '{2'b00, 2'b11, 2'b01, 2'b10};
      done_seen = 0;
      for (int ch = 0; ch < 4; ch++) begin
         for (int i = 0; i < S + W; i++) begin
            sensor_freq = sensor_val(n[ch], i);
            if (ch == repulse_ch && i == 5) begin
               start     = 1'b1;
               scale_sel = 2'b10;
            end else begin
               start = 1'b0;
            end
            if (i == 60) check("s23_filter", s23, code[ch]);
            if (done) done_seen++;
            step();
         end
      end
      sensor_freq = 1'b0;
      start       = 1'b0;
      check("no_done_mid_scan", done_seen, 0);
   endtask

   task automatic finish_scan(input int er, input int eg, input int eb, input int ec,
                              input logic [1:0] ecol);
      check("classify_done_low", done, 1'b0);
      check("classify_busy", busy, 1'b1);
      step();
      check("done_pulse", done, 1'b1);
      check("done_busy_low", busy, 1'b0);
      check("red_cnt", red_cnt, er);
      check("green_cnt", green_cnt, eg);
      check("blue_cnt", blue_cnt, eb);
      check("clear_cnt", clear_cnt, ec);
      check("color", color, ecol);
   endtask

   initial begin
      int done_seen;
      rst         = 1'b1;
      start       = 1'b0;
      continuous  = 1'b0;
      sensor_freq = 1'b0;
      scale_sel   = 2'b00;
      step();
      step();
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_s01", s01, 2'b11);
      check("rst_s23", s23, 2'b00);
      check("rst_red_cnt", red_cnt, 0);
      check("rst_color", color, 2'd0);
      rst = 1'b0;
      step();

      // Equal 25-edge windows: red wins the tie, 2500 >= 1000.
      start_scan(2'b10);
      drive_scan(-1, -1, -1, -1, -1);
      finish_scan(25, 25, 25, 25, 2'd1);
      step();
      check("done_one_cycle", done, 1'b0);
      repeat (5) step();
      check("hold_red_cnt", red_cnt, 25);
      check("hold_color", color, 2'd1);

      // Green 30: 3000 >= 50*40 = 2000.
      start_scan(2'b01);
      drive_scan(10, 30, 5, 50, -1);
      finish_scan(10, 30, 5, 50, 2'd2);
      step();

      // Reset during the blue measurement window.
      start_scan(2'b00);
      for (int i = 0; i < 2 * (S + W) + 50; i++) begin
         sensor_freq = i[0];
         step();
      end
      rst = 1'b1;
      step();
      rst         = 1'b0;
      sensor_freq = 1'b0;
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_green_cnt", green_cnt, 0);
      check("midrst_clear_cnt", clear_cnt, 0);
      check("midrst_color", color, 2'd0);
      check("midrst_s01", s01, 2'b11);
      check("midrst_s23", s23, 2'b00);
      done_seen = 0;
      for (int i = 0; i < 500; i++) begin
         if (done) done_seen++;
         step();
      end
      check("midrst_no_done", done_seen, 0);

      // Reset beats start in the same cycle.
      rst       = 1'b1;
      start     = 1'b1;
      scale_sel = 2'b00;
      step();
      rst   = 1'b0;
      start = 1'b0;
      check("rst_over_start_busy", busy, 1'b0);
      check("rst_over_start_s01", s01, 2'b11);
      step();
      check("rst_over_start_idle", busy, 1'b0);

      // Green 15: 1500 < 2000, below threshold.
      start_scan(2'b11);
      drive_scan(10, 15, 5, 50, -1);
      finish_scan(10, 15, 5, 50, 2'd0);
      step();

      // No edges: clear is zero, colour none, done still pulses.
      start_scan(2'b00);
      drive_scan(0, 0, 0, 0, -1);
      finish_scan(0, 0, 0, 0, 2'd0);
      step();

      // Start re-pulsed mid-scan is ignored; continuous restarts with re-sampled scale.
      start_scan(2'b01);
      continuous = 1'b1;
      drive_scan(0, 0, 0, 0, 1);
      check("repulse_s01_kept", s01, 2'b01);
      finish_scan(0, 0, 0, 0, 2'd0);
      step();
      check("cont_busy_back", busy, 1'b1);
      check("cont_done_low", done, 1'b0);
      check("cont_s01_resampled", s01, 2'b10);
      continuous = 1'b0;
      scale_sel  = 2'b11;
      drive_scan(-1, -1, -1, -1, -1);
      finish_scan(25, 25, 25, 25, 2'd1);
      step();
      check("cont_stop_busy", busy, 1'b0);
      check("cont_stop_done", done, 1'b0);
      check("cont_stop_s01", s01, 2'b10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/color_scan_sequencer.md
COLOR_SCAN_SEQUENCER -- requirements
Module: color_scan_sequencer

Interface
REQ-001 Parameter WINDOW_CYCLES, default 100000: clk cycles per per-channel count window.
REQ-002 Parameter SETTLE_CYCLES, default 1000: clk cycles of filter-settle blanking before each window.
REQ-003 Parameter CNT_W, default 17: width of every channel count (must hold WINDOW_CYCLES/2).
REQ-004 Parameter THRESH_PCT, default 40: minimum dominant-channel share of clear, in percent.
REQ-005 clk  in  1  sole clock; all logic on posedge clk.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 start  in  1  one-cycle request to begin one four-channel scan.
REQ-008 continuous  in  1  when 1, a new scan starts automatically after each scan completes.
REQ-009 scale_sel  in  2  sensor frequency-scaling code, sampled at scan start.
REQ-010 sensor_freq  in  1  asynchronous sensor square-wave output.
REQ-011 s01  out  2  sensor scaling pins {S0,S1}.
REQ-012 s23  out  2  sensor filter pins {S2,S3}.
REQ-013 busy  out  1  high from scan acceptance until done.
REQ-014 done  out  1  one-cycle pulse when results update.
REQ-015 red_cnt, green_cnt, blue_cnt, clear_cnt  out  CNT_W each  latched counts of last scan.
REQ-016 color  out  2  classification: 0 none, 1 red, 2 green, 3 blue.

Function
REQ-017 FSM states IDLE, SETTLE, MEASURE, CLASSIFY; scan order red, green, blue, clear.
REQ-018 IDLE: on start=1, latch scale_sel into s01, set channel=red, go SETTLE next cycle; busy asserts that next cycle.
REQ-019 start while busy=1 is ignored (no queueing).
REQ-020 Filter codes on s23: red 00, blue 01, clear 10, green 11; s23 changes only on entry to SETTLE.
REQ-021 SETTLE lasts exactly SETTLE_CYCLES cycles; edges are not counted.
REQ-022 MEASURE lasts exactly WINDOW_CYCLES cycles; counts rising edges of synchronized sensor_freq.
REQ-023 sensor_freq passes through a 2-flop synchronizer; an edge is sync_q1=1 & sync_q2=0.
REQ-024 Channel count saturates at 2^CNT_W-1, never wraps.
REQ-025 End of MEASURE: store count in a shadow register for that channel, clear counter, advance channel; after clear go CLASSIFY.
REQ-026 CLASSIFY (1 cycle): dominant = max of red, green, blue shadows, ties resolved red > green > blue.
REQ-027 color = dominant code if dominant*100 >= clear*THRESH_PCT and clear != 0, else 0; products computed at CNT_W+7 bits, no truncation.
REQ-028 In CLASSIFY cycle, shadow counts copy to *_cnt outputs and color updates; done pulses the following cycle together with return to IDLE.
REQ-029 Outputs *_cnt and color hold between scans; partial scans never update them.
REQ-030 Latency: start accepted at cycle t gives done at t+2+4*(SETTLE_CYCLES+WINDOW_CYCLES).
REQ-031 continuous=1 at done cycle: next cycle behaves as an accepted start (s01 re-sampled); busy deasserts for exactly that one cycle.

Reset
REQ-032 rst=1 at any clk edge forces IDLE, busy=0, done=0, s23=00, s01=11, all counts, shadows and color =0, synchronizer flops =0.
REQ-033 rst mid-scan abandons the scan with no done pulse and no output update.
REQ-034 rst dominates start in the same cycle.

Structure
REQ-035 Package color_pkg holds the state enum, channel enum, filter-code constants and color-code constants.
REQ-036 One sub-module edge_counter: synchronizer, edge detect, saturating counter with clear and enable inputs.

Verification (bench uses WINDOW_CYCLES=100, SETTLE_CYCLES=10, CNT_W=8, THRESH_PCT=40)
REQ-037 sensor_freq period 4 clk on all channels, one start -> each count 25, color=1 (tie red), done at t+442.
REQ-038 Edges per window R=10, G=30, B=5, C=50 -> color=2; R=10, G=15, B=5, C=50 -> color=0 (30%<40%).
REQ-039 sensor_freq held 0 -> all counts 0, color=0, done still pulses.
REQ-040 rst asserted during blue MEASURE -> busy=0 next cycle, outputs retain reset values, no done.
REQ-041 start re-pulsed while busy, then continuous=1 -> exactly one done per 440-cycle scan, one-cycle busy gap, s01 re-sampled each scan.
